// File: rtl/conv_tile_scheduler_pkg.sv
// Shared constants, FSM encoding and ceil-divide helper for conv_tile_scheduler.
package conv_tile_scheduler_pkg;

  localparam int DEF_TENSOR_W = 8;
  localparam int DEF_KERNEL_W = 4;
  localparam int DEF_STRIDE_W = 3;
  localparam int DEF_KNUM_W   = 8;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_S2P      = 8;
  localparam int DEF_TNUM_W   = 2 * DEF_TENSOR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DIV   = 3'd2,
    ST_CALC  = 3'd3,
    ST_ISSUE = 3'd4,
    ST_WAIT  = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_e;

  // ceil(x / 2**sh): shift, then round up if any discarded bit was set
  function automatic logic [DEF_TNUM_W-1:0] ceil_div_s2p(input logic [DEF_TNUM_W-1:0] x,
                                                         input int unsigned sh);
    logic [DEF_TNUM_W-1:0] mask;
    mask = (DEF_TNUM_W'(1) << sh) - DEF_TNUM_W'(1);
    return (x >> sh) + {{(DEF_TNUM_W-1){1'b0}}, |(x & mask)};
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// Host config and GEMM tile handshake bundle; slave = scheduler, master = host/GEMM side.
interface conv_tile_scheduler_if
  import conv_tile_scheduler_pkg::*;
#(
  parameter int TENSOR_W = DEF_TENSOR_W,
  parameter int KERNEL_W = DEF_KERNEL_W,
  parameter int STRIDE_W = DEF_STRIDE_W,
  parameter int KNUM_W   = DEF_KNUM_W,
  parameter int ADDR_W   = DEF_ADDR_W
);
  localparam int TNUM_W = 2 * TENSOR_W + 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [TENSOR_W-1:0] tensor_size;
  logic [KERNEL_W-1:0] kernel_size;
  logic [STRIDE_W-1:0] stride;
  logic [KNUM_W-1:0]   kernel_num;
  logic                cfg_err;
  logic [TNUM_W-1:0]   img2col_t_num;
  logic [ADDR_W-1:0]   switch_kernel_group_addnums;
  logic [ADDR_W-1:0]   switch_kernel_addnums;
  logic                tile_start;
  logic [TNUM_W-1:0]   tile_idx;
  logic [KNUM_W-1:0]   group_idx;
  logic                tile_done;
  logic                busy;
  logic                conv_done;

  modport slave (
    input  cfg_valid, tensor_size, kernel_size, stride, kernel_num, tile_done,
    output cfg_ready, cfg_err, img2col_t_num, switch_kernel_group_addnums,
           switch_kernel_addnums, tile_start, tile_idx, group_idx, busy, conv_done
  );

  modport master (
    output cfg_valid, tensor_size, kernel_size, stride, kernel_num, tile_done,
    input  cfg_ready, cfg_err, img2col_t_num, switch_kernel_group_addnums,
           switch_kernel_addnums, tile_start, tile_idx, group_idx, busy, conv_done
  );

endinterface

// File: rtl/conv_tile_scheduler_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses when the quotient is valid.
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] quo_d, quo_q;
  logic [DIVISOR_W-1:0]  rem_d, rem_q;
  logic [DIVISOR_W-1:0]  dvs_d, dvs_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic                  done_d, done_q;
  logic [DIVISOR_W:0]    rem_shift_s;
  logic [DIVISOR_W:0]    rem_sub_s;

  // The dividend register doubles as the quotient shift register
  always_comb begin
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    rem_shift_s = {rem_q, quo_q[DIVIDEND_W-1]};
    rem_sub_s   = rem_shift_s - {1'b0, dvs_q};
    if (start) begin
      quo_d = dividend;
      rem_d = {DIVISOR_W{1'b0}};
      dvs_d = divisor;
      cnt_d = CNT_W'(DIVIDEND_W);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      if (rem_shift_s >= {1'b0, dvs_q}) begin
        rem_d = rem_sub_s[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d = rem_shift_s[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_q  <= {DIVIDEND_W{1'b0}};
      rem_q  <= {DIVISOR_W{1'b0}};
      dvs_q  <= {DIVISOR_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Convolution layer tile scheduler: derives output geometry, then issues one start per (group, tile).
// Optional macro CONV_SCHED_PERF_EN adds a saturating 32-bit busy-cycle counter on perf_cycles.
module conv_tile_scheduler
  import conv_tile_scheduler_pkg::*;
#(
  parameter int TENSOR_W = DEF_TENSOR_W,
  parameter int KERNEL_W = DEF_KERNEL_W,
  parameter int STRIDE_W = DEF_STRIDE_W,
  parameter int KNUM_W   = DEF_KNUM_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int S2P      = DEF_S2P
) (
  input  logic                  clk,
  input  logic                  rstn,
  conv_tile_scheduler_if.slave  bus
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);
  localparam int TNUM_W   = 2 * TENSOR_W + 1;
  localparam int S2P_LOG2 = $clog2(S2P);

  sched_state_e        state_d, state_q;
  logic                calc_ph_d, calc_ph_q;
  logic [TENSOR_W-1:0] tsz_d, tsz_q;
  logic [KERNEL_W-1:0] ksz_d, ksz_q;
  logic [STRIDE_W-1:0] str_d, str_q;
  logic [KNUM_W-1:0]   knum_d, knum_q;
  logic [TNUM_W-1:0]   ofs_d, ofs_q;
  logic [TNUM_W-1:0]   grp_d, grp_q;
  logic [TNUM_W-1:0]   t_num_d, t_num_q;
  logic [ADDR_W-1:0]   sgj_d, sgj_q;
  logic [ADDR_W-1:0]   skj_d, skj_q;
  logic [TNUM_W-1:0]   tile_idx_d, tile_idx_q;
  logic [KNUM_W-1:0]   group_idx_d, group_idx_q;
  logic                cfg_ready_d, cfg_ready_q;
  logic                cfg_err_d, cfg_err_q;
  logic                tile_start_d, tile_start_q;
  logic                conv_done_d, conv_done_q;
  logic                busy_d, busy_q;

  logic                accept_s;
  logic                illegal_s;
  logic                div_start_s;
  logic                div_done_s;
  logic [TENSOR_W-1:0] div_quo_s;
  logic [TENSOR_W-1:0] ksz_ext_s;
  logic [TNUM_W-1:0]   o_dim_s;
  logic [TNUM_W-1:0]   t_num_s;
  logic [ADDR_W-1:0]   ofs_a_s;
  logic [ADDR_W-1:0]   tnum_a_s;
  logic                tile_last_s;
  logic                grp_last_s;

  assign accept_s    = (state_q == ST_IDLE) && bus.cfg_valid;
  assign ksz_ext_s   = {{(TENSOR_W-KERNEL_W){1'b0}}, ksz_q};
  assign illegal_s   = (str_q == {STRIDE_W{1'b0}}) || (ksz_q == {KERNEL_W{1'b0}}) ||
                       (knum_q == {KNUM_W{1'b0}}) || (ksz_ext_s > tsz_q);
  assign o_dim_s     = TNUM_W'(div_quo_s) + TNUM_W'(1);
  assign t_num_s     = ceil_div_s2p(ofs_q, S2P_LOG2);
  assign ofs_a_s     = ADDR_W'(ofs_q);
  assign tnum_a_s    = ADDR_W'(t_num_s);
  assign tile_last_s = (tile_idx_q == t_num_q - TNUM_W'(1));
  assign grp_last_s  = ({{(TNUM_W-KNUM_W){1'b0}}, group_idx_q} == grp_q - TNUM_W'(1));

  seq_divider #(
    .DIVIDEND_W (TENSOR_W),
    .DIVISOR_W  (STRIDE_W)
  ) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start_s),
    .dividend (tsz_q - ksz_ext_s),
    .divisor  (str_q),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    calc_ph_d   = calc_ph_q;
    tsz_d       = tsz_q;
    ksz_d       = ksz_q;
    str_d       = str_q;
    knum_d      = knum_q;
    ofs_d       = ofs_q;
    grp_d       = grp_q;
    t_num_d     = t_num_q;
    sgj_d       = sgj_q;
    skj_d       = skj_q;
    tile_idx_d  = tile_idx_q;
    group_idx_d = group_idx_q;
    cfg_err_d   = 1'b0;
    div_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          tsz_d       = bus.tensor_size;
          ksz_d       = bus.kernel_size;
          str_d       = bus.stride;
          knum_d      = bus.kernel_num;
          tile_idx_d  = {TNUM_W{1'b0}};
          group_idx_d = {KNUM_W{1'b0}};
          state_d     = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (illegal_s) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          div_start_s = 1'b1;
          state_d     = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          calc_ph_d = 1'b0;
          state_d   = ST_CALC;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_CALC: begin
        // Phase 0 registers the square; phase 1 derives everything from it
        if (!calc_ph_q) begin
          ofs_d     = o_dim_s * o_dim_s;
          grp_d     = ceil_div_s2p({{(TNUM_W-KNUM_W){1'b0}}, knum_q}, S2P_LOG2);
          calc_ph_d = 1'b1;
        end else begin
          t_num_d   = t_num_s;
          sgj_d     = (ofs_a_s << S2P_LOG2) - ((tnum_a_s - ADDR_W'(1)) << S2P_LOG2);
          skj_d     = ofs_a_s - ADDR_W'(S2P) + ADDR_W'(1);
          calc_ph_d = 1'b0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.tile_done) begin
          if (tile_last_s) begin
            tile_idx_d  = {TNUM_W{1'b0}};
            group_idx_d = group_idx_q + KNUM_W'(1);
          end else begin
            tile_idx_d  = tile_idx_q + TNUM_W'(1);
          end
          state_d = (tile_last_s && grp_last_s) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cfg_ready_d  = (state_d == ST_IDLE);
    tile_start_d = (state_d == ST_ISSUE);
    conv_done_d  = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any run in progress
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      calc_ph_q    <= 1'b0;
      tsz_q        <= {TENSOR_W{1'b0}};
      ksz_q        <= {KERNEL_W{1'b0}};
      str_q        <= {STRIDE_W{1'b0}};
      knum_q       <= {KNUM_W{1'b0}};
      ofs_q        <= {TNUM_W{1'b0}};
      grp_q        <= {TNUM_W{1'b0}};
      t_num_q      <= {TNUM_W{1'b0}};
      sgj_q        <= {ADDR_W{1'b0}};
      skj_q        <= {ADDR_W{1'b0}};
      tile_idx_q   <= {TNUM_W{1'b0}};
      group_idx_q  <= {KNUM_W{1'b0}};
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
      tile_start_q <= 1'b0;
      conv_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      calc_ph_q    <= calc_ph_d;
      tsz_q        <= tsz_d;
      ksz_q        <= ksz_d;
      str_q        <= str_d;
      knum_q       <= knum_d;
      ofs_q        <= ofs_d;
      grp_q        <= grp_d;
      t_num_q      <= t_num_d;
      sgj_q        <= sgj_d;
      skj_q        <= skj_d;
      tile_idx_q   <= tile_idx_d;
      group_idx_q  <= group_idx_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      tile_start_q <= tile_start_d;
      conv_done_q  <= conv_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.cfg_ready                   = cfg_ready_q;
  assign bus.cfg_err                     = cfg_err_q;
  assign bus.img2col_t_num               = t_num_q;
  assign bus.switch_kernel_group_addnums = sgj_q;
  assign bus.switch_kernel_addnums       = skj_q;
  assign bus.tile_start                  = tile_start_q;
  assign bus.tile_idx                    = tile_idx_q;
  assign bus.group_idx                   = group_idx_q;
  assign bus.busy                        = busy_q;
  assign bus.conv_done                   = conv_done_q;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_d, perf_q;

  // Busy-cycle counter: cleared on accept, saturating, held while idle
  always_comb begin
    if (accept_s) begin
      perf_d = 32'd0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: table vectors, random configs vs. arithmetic model, corner sequences.
`timescale 1ns/1ps
module tb_conv_tile_scheduler;
  import conv_tile_scheduler_pkg::*;

  localparam int LATENCY = DEF_TENSOR_W + 4;

  typedef struct {
    int t; int k; int s; int kn;
    bit err;
    int tnum; int grp; int gj; int kj;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  conv_tile_scheduler_if bus ();
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  conv_tile_scheduler dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef CONV_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rem_tnum = 0;
  int rem_gj   = 0;
  int rem_kj   = 0;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Geometry straight from the layer arithmetic
  function automatic vec_t model(input int t, input int k, input int s, input int kn);
    vec_t v;
    int o;
    int ofs;
    v = '{t, k, s, kn, 1'b0, 0, 0, 0, 0};
    v.err = (s == 0) || (k == 0) || (kn == 0) || (k > t);
    if (!v.err) begin
      o      = (t - k) / s + 1;
      ofs    = o * o;
      v.tnum = (ofs + DEF_S2P - 1) / DEF_S2P;
      v.grp  = (kn + DEF_S2P - 1) / DEF_S2P;
      v.gj   = (ofs * DEF_S2P - (v.tnum - 1) * DEF_S2P) % 65536;
      v.kj   = (ofs - DEF_S2P + 1 + 65536) % 65536;
    end
    return v;
  endfunction

  task automatic chk_derived(input string tag, input int tnum, input int gj, input int kj);
    chk({tag, "_t_num"}, 32'(bus.img2col_t_num), 32'(tnum));
    chk({tag, "_grp_jump"}, 32'(bus.switch_kernel_group_addnums), 32'(gj));
    chk({tag, "_krn_jump"}, 32'(bus.switch_kernel_addnums), 32'(kj));
  endtask

  task automatic drive_cfg(input vec_t v);
    bus.cfg_valid   = 1'b1;
    bus.tensor_size = DEF_TENSOR_W'(v.t);
    bus.kernel_size = DEF_KERNEL_W'(v.k);
    bus.stride      = DEF_STRIDE_W'(v.s);
    bus.kernel_num  = DEF_KNUM_W'(v.kn);
  endtask

  task automatic run_cfg(input vec_t v, input int dmin, input int dmax, input bit glitch);
    int k, starts, dones, errs, pend, first_k, busy_cnt, n_total, budget;
    n_total = v.err ? 0 : v.tnum * v.grp;
    budget  = 40 + n_total * (dmax + 3);
    @(negedge clk);
    chk("cfg_ready_before", 32'(bus.cfg_ready), 32'd1);
    drive_cfg(v);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    k = 0; starts = 0; dones = 0; errs = 0; pend = 0; first_k = -1; busy_cnt = 0;
    while (k < budget && dones == 0 && !(v.err && errs > 0)) begin
      bus.tile_done = 1'b0;
      bus.cfg_valid = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.cfg_err) errs++;
      if (bus.conv_done) dones++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) bus.tile_done = 1'b1;
      end
      if (bus.tile_start) begin
        if (starts == 0) first_k = k;
        if (v.tnum > 0) begin
          chk("tile_idx", 32'(bus.tile_idx), 32'(starts % v.tnum));
          chk("group_idx", 32'(bus.group_idx), 32'(starts / v.tnum));
        end
        starts++;
        pend = $urandom_range(dmax, dmin);
      end
      if (glitch && k == 5) bus.tile_done = 1'b1;
      if (glitch && k == 15) drive_cfg('{9, 2, 1, 64, 1'b0, 0, 0, 0, 0});
      @(negedge clk);
      k++;
    end
    bus.tile_done = 1'b0;
    bus.cfg_valid = 1'b0;
    if (v.err) begin
      chk("cfg_err_pulse", 32'(errs), 32'd1);
      chk("err_no_start", 32'(starts), 32'd0);
      chk("err_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      chk_derived("err_hold", rem_tnum, rem_gj, rem_kj);
      @(negedge clk);
      chk("cfg_err_one_cycle", 32'(bus.cfg_err), 32'd0);
    end else begin
      chk("conv_done_seen", 32'(dones), 32'd1);
      chk("tile_start_count", 32'(starts), 32'(n_total));
      chk("first_start_latency", 32'(first_k), 32'(LATENCY));
      chk("no_cfg_err", 32'(errs), 32'd0);
      chk_derived("run", v.tnum, v.gj, v.kj);
      @(negedge clk);
      chk("busy_drop", 32'(bus.busy), 32'd0);
      chk("conv_done_one_cycle", 32'(bus.conv_done), 32'd0);
      chk("cfg_ready_after", 32'(bus.cfg_ready), 32'd1);
`ifdef CONV_SCHED_PERF_EN
      chk("perf_cycles", perf_cycles, 32'(busy_cnt));
`endif
      rem_tnum = v.tnum; rem_gj = v.gj; rem_kj = v.kj;
    end
  endtask

  initial begin
    vec_t v;
    int k;
    bit seen;
    tbl[0] = '{6, 3, 1, 8, 1'b0, 2, 1, 120, 9};
    tbl[1] = '{7, 3, 2, 20, 1'b0, 2, 3, 64, 2};
    tbl[2] = '{6, 3, 0, 8, 1'b1, 0, 0, 0, 0};
    tbl[3] = '{4, 5, 1, 8, 1'b1, 0, 0, 0, 0};
    tbl[4] = '{6, 0, 1, 8, 1'b1, 0, 0, 0, 0};
    tbl[5] = '{6, 3, 1, 0, 1'b1, 0, 0, 0, 0};
    tbl[6] = '{255, 15, 7, 1, 1'b0, 154, 1, 8576, 1218};
    tbl[7] = '{7, 7, 7, 9, 1'b0, 1, 2, 8, 65530};
    tbl[8] = '{20, 4, 3, 8, 1'b0, 5, 1, 256, 29};
    tbl[9] = '{100, 1, 1, 1, 1'b0, 1250, 1, 4472, 9993};

    rstn = 1'b0;
    bus.cfg_valid = 1'b0; bus.tile_done = 1'b0;
    bus.tensor_size = '0; bus.kernel_size = '0; bus.stride = '0; bus.kernel_num = '0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tile_start", 32'(bus.tile_start), 32'd0);
    chk("rst_conv_done", 32'(bus.conv_done), 32'd0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    chk_derived("rst", 0, 0, 0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) run_cfg(tbl[i], 1, 2, 1'b0);

    // Mid-run config offer and stray tile_done must both be ignored
    run_cfg(tbl[1], 1, 3, 1'b1);
    // Fixed 5-cycle tile latency
    run_cfg(tbl[0], 5, 5, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int t, kk, s, kn;
      t  = $urandom_range(20, 1);
      kk = $urandom_range((t > 15) ? 15 : t, 1);
      s  = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(7, 1);
      kn = $urandom_range(24, 1);
      v  = model(t, kk, s, kn);
      run_cfg(v, 1, 3, 1'b0);
    end

    // Reset while waiting on the first tile
    @(negedge clk);
    drive_cfg(tbl[0]);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      if (bus.tile_start) seen = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("abort_reached_wait", 32'(seen), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_tile_start", 32'(bus.tile_start), 32'd0);
    chk("abort_tile_idx", 32'(bus.tile_idx), 32'd0);
    chk("abort_group_idx", 32'(bus.group_idx), 32'd0);
    chk_derived("abort", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_conv_done", 32'(bus.conv_done), 32'd0);
    end
    rstn = 1'b1;
    rem_tnum = 0; rem_gj = 0; rem_kj = 0;
    run_cfg(tbl[1], 1, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
